// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both ends of the async FIFO: Gray/binary conversion at the FIFO pointer width.
package fifo_pkg;

    localparam int FIFO_PTR_WIDTH = 3;

    // Pointers carry one extra wrap bit above the address bits.
    typedef logic [FIFO_PTR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[FIFO_PTR_WIDTH] = g[FIFO_PTR_WIDTH];
        for (int i = FIFO_PTR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser; 2-cycle latency, no backpressure (free-running sampler).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/rd_fwft_ctrl.sv
// Read side of the async FIFO: syncs the Gray write pointer, issues RAM reads, presents FWFT data.
// g_wptr change to dout_valid is 4 rdclk edges; dout holds while dout_ready is low, prefetch stops at 2 words.
module rd_fwft_ctrl
    import fifo_pkg::*;
#(
    // Gray conversions are sized by the package pointer width; keep these in step.
    parameter int PTR_WIDTH  = FIFO_PTR_WIDTH,
    parameter int DATA_WIDTH = 8,
    parameter int AE_THRESH  = 1
) (
    input  logic                  rdclk,
    input  logic                  rrst_n,
    input  logic [PTR_WIDTH:0]    g_wptr,
    output logic [PTR_WIDTH:0]    g_rptr,
    output logic [PTR_WIDTH-1:0]  rd_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  fifo_empty,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    rd_level
);

    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    logic [PW-1:0]         g_wptr_sync;
    logic [PW-1:0]         b_wptr_sync;
    logic [PW-1:0]         b_rptr_q, b_rptr_d;
    logic [PW-1:0]         g_rptr_q, g_rptr_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [PW-1:0]         rd_level_q, rd_level_d;
    logic                  almost_empty_q, almost_empty_d;

    logic                  ram_empty;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            commit_cnt;

    sync_2ff #(
        .WIDTH (PW)
    ) u_wptr_sync (
        .clk   (rdclk),
        .rst_n (rrst_n),
        .d     (g_wptr),
        .q     (g_wptr_sync)
    );

    always_comb begin
        b_wptr_sync = gray2bin(g_wptr_sync);
        ram_empty   = (g_rptr_q == g_wptr_sync);
        pop         = (buf_cnt_q != 2'd0) && dout_ready;
        push        = inflight_q;
        // Words already held or on their way, net of this cycle's pop, must leave room for one more.
        commit_cnt  = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue       = !ram_empty && (commit_cnt < 3'd2);

        b_rptr_d    = b_rptr_q + {{PTR_WIDTH{1'b0}}, issue};
        g_rptr_d    = bin2gray(b_rptr_d);
        inflight_d  = issue;

        rd_level_d     = b_wptr_sync - b_rptr_q;
        almost_empty_d = (rd_level_d <= AE_LVL);
    end

    always_comb begin
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        buf_cnt_d = buf_cnt_q;
        if (push && !pop) begin
            if (buf_cnt_q == 2'd0) begin
                buf0_d = rd_data;
            end else begin
                buf1_d = rd_data;
            end
            buf_cnt_d = buf_cnt_q + 2'd1;
        end else if (!push && pop) begin
            buf0_d    = buf1_q;
            buf_cnt_d = buf_cnt_q - 2'd1;
        end else if (push && pop) begin
            // Head leaves and the new word lands behind whatever remains.
            if (buf_cnt_q == 2'd1) begin
                buf0_d = rd_data;
            end else begin
                buf0_d = buf1_q;
                buf1_d = rd_data;
            end
        end
    end

    always_ff @(posedge rdclk or negedge rrst_n) begin
        if (!rrst_n) begin
            b_rptr_q       <= '0;
            g_rptr_q       <= '0;
            inflight_q     <= 1'b0;
            buf_cnt_q      <= 2'd0;
            buf0_q         <= '0;
            buf1_q         <= '0;
            rd_level_q     <= '0;
            almost_empty_q <= 1'b1;
        end else begin
            b_rptr_q       <= b_rptr_d;
            g_rptr_q       <= g_rptr_d;
            inflight_q     <= inflight_d;
            buf_cnt_q      <= buf_cnt_d;
            buf0_q         <= buf0_d;
            buf1_q         <= buf1_d;
            rd_level_q     <= rd_level_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign g_rptr       = g_rptr_q;
    assign rd_addr      = b_rptr_q[PTR_WIDTH-1:0];
    assign mem_rd_en    = issue;
    assign dout         = buf0_q;
    assign dout_valid   = (buf_cnt_q != 2'd0);
    assign fifo_empty   = (buf_cnt_q == 2'd0);
    assign almost_empty = almost_empty_q;
    assign rd_level     = rd_level_q;

endmodule

// File: tb/tb_rd_fwft_ctrl.sv
// Bench for rd_fwft_ctrl: write-domain and RAM model, expected-word queue, negedge monitor.
module tb_rd_fwft_ctrl;

    logic       rdclk = 1'b0;
    logic       rrst_n;
    logic [3:0] g_wptr;
    logic [3:0] g_rptr;
    logic [2:0] rd_addr;
    logic       mem_rd_en;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       fifo_empty;
    logic       almost_empty;
    logic [3:0] rd_level;

    always #5 rdclk = ~rdclk;

    rd_fwft_ctrl #(
        .PTR_WIDTH  (3),
        .DATA_WIDTH (8),
        .AE_THRESH  (1)
    ) dut (
        .rdclk        (rdclk),
        .rrst_n       (rrst_n),
        .g_wptr       (g_wptr),
        .g_rptr       (g_rptr),
        .rd_addr      (rd_addr),
        .mem_rd_en    (mem_rd_en),
        .rd_data      (rd_data),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .fifo_empty   (fifo_empty),
        .almost_empty (almost_empty),
        .rd_level     (rd_level)
    );

    logic [7:0] ram [8];
    always @(posedge rdclk) begin
        if (mem_rd_en) rd_data <= ram[rd_addr];
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_written = 0;
    int         n_popped = 0;
    logic [7:0] exp_q [$];

    function automatic logic [3:0] g_of(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] b_of(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rdclk);
        #2;
    endtask

    task automatic write_word(input logic [7:0] d);
        int c;
        c = 0;
        while ((n_written - n_popped) >= 8 && c < 100) begin
            tick();
            c++;
        end
        if ((n_written - n_popped) >= 8) chk("write_space", n_written - n_popped, 7);
        ram[n_written % 8] = d;
        n_written++;
        g_wptr = g_of(4'(n_written));
        exp_q.push_back(d);
    endtask

    task automatic wait_drain(input int budget, input bit rnd);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
            dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        chk("drain_left", exp_q.size(), 0);
        dout_ready = 1'b0;
    endtask

    task automatic do_reset();
        #1;
        rrst_n     = 1'b0;
        g_wptr     = 4'd0;
        dout_ready = 1'b0;
        n_written  = 0;
        n_popped   = 0;
        exp_q.delete();
        #1;
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_g_rptr", g_rptr, 0);
        tick();
        tick();
        rrst_n = 1'b1;
        tick();
    endtask

    // Monitor: scoreboard pops, hold-under-backpressure, Gray step and address consistency.
    logic       hold_v = 1'b0;
    logic [7:0] hold_d;
    logic [3:0] prev_g;
    logic       prev_ok = 1'b0;
    logic       wrap_seen = 1'b0;
    logic [3:0] mon_b;
    logic [7:0] mon_e;

    always @(negedge rdclk) begin
        if (rrst_n !== 1'b1) begin
            hold_v  = 1'b0;
            prev_ok = 1'b0;
        end else begin
            chk("fifo_empty_vs_valid", fifo_empty, !dout_valid);
            if (hold_v) begin
                chk("hold_valid", dout_valid, 1);
                chk("hold_dout", dout, hold_d);
            end
            if (prev_ok && g_rptr !== prev_g) begin
                chk("g_rptr_step", g_rptr, g_of(b_of(prev_g) + 4'd1));
                if (prev_g == 4'b1000 && g_rptr == 4'b0000) wrap_seen = 1'b1;
            end
            mon_b = b_of(g_rptr);
            chk("rd_addr", rd_addr, mon_b[2:0]);
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", dout_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("dout", dout, mon_e);
                    n_popped++;
                end
            end
            hold_v  = dout_valid && !dout_ready;
            hold_d  = dout;
            prev_g  = g_rptr;
            prev_ok = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ghost;
        bit seen;

        rrst_n     = 1'b1;
        g_wptr     = 4'd0;
        dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) ram[i] = 8'h00;

        // Asynchronous reset mid-cycle
        #7 rrst_n = 1'b0;
        #1;
        chk("rst_g_rptr", g_rptr, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_fifo_empty", fifo_empty, 1);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_rd_level", rd_level, 0);
        chk("rst_dout", dout, 0);
        tick();
        tick();
        rrst_n = 1'b1;
        tick();

        // Single word: visible after the fourth edge
        write_word(8'hA5);
        tick(); tick(); tick();
        chk("lat3_valid", dout_valid, 0);
        tick();
        chk("lat4_valid", dout_valid, 1);
        chk("lat4_dout", dout, 8'hA5);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("single_empty", fifo_empty, 1);
        chk("single_g_rptr", g_rptr, 4'b0001);
        chk("single_level", rd_level, 0);
        chk("single_ae", almost_empty, 1);
        chk("single_q", exp_q.size(), 0);

        // Backpressure: 8 words, random ready
        for (int i = 0; i < 8; i++) begin
            write_word(8'h10 + 8'(i));
            dout_ready = 1'($urandom_range(0, 1));
            tick();
        end
        wait_drain(300, 1'b1);

        // Wrap: 20 more words streamed with ready held high
        for (int i = 0; i < 20; i++) begin
            dout_ready = 1'b1;
            write_word(8'h40 + 8'(i));
            tick();
        end
        wait_drain(100, 1'b0);
        tick();
        chk("wrap_g_rptr", g_rptr, 4'b1011);
        chk("wrap_rd_addr", rd_addr, 3'd5);
        chk("wrap_seen", wrap_seen, 1);
        chk("wrap_level", rd_level, 0);

        // Full level: gray(8) with read pointer at 0, consumer stalled
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ram[i] = 8'h80 + 8'(i);
            exp_q.push_back(8'h80 + 8'(i));
        end
        n_written = 8;
        g_wptr    = 4'b1100;
        tick(); tick(); tick();
        chk("full_level8", rd_level, 8);
        chk("full_ae", almost_empty, 0);
        tick(); tick();
        chk("full_level6", rd_level, 6);
        tick(); tick(); tick();
        chk("full_level6_hold", rd_level, 6);
        chk("full_no_issue", mem_rd_en, 0);
        chk("full_valid", dout_valid, 1);
        chk("full_dout", dout, 8'h80);
        wait_drain(100, 1'b1);

        // Reset with a read in flight: nothing may appear until a fresh write
        for (int i = 0; i < 4; i++) write_word(8'h20 + 8'(i));
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = mem_rd_en;
        end
        chk("burst_issue_seen", seen, 1);
        tick();
        do_reset();
        ghost = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (dout_valid !== 1'b0 || mem_rd_en !== 1'b0) ghost = 1'b1;
        end
        chk("post_reset_ghost", ghost, 0);
        write_word(8'h3C);
        wait_drain(20, 1'b0);
        tick();
        chk("post_reset_g_rptr", g_rptr, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
